// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier (MUL/MLA, optional S) that stalls Execute while running
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic             flush,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] acc_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic [1:0]       flag_write
);
  localparam int N = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a_reg, b_reg, product, sum;
  logic [CW-1:0] count;
  logic s_reg, last;
  assign sum = product + a_reg * WIDTH'(b_reg[STEP-1:0]);
  assign last = count == LAST;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = flush ? IDLE : state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE && !flush;
    flag_write = done ? {s_reg, 1'b0} : 2'b00;
    alu_flags = done ? {product[WIDTH-1], product == '0, 2'b00} : 4'b0000;
  end
  // result is loaded on entry to DONE so it holds the last product until the next completion
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      product <= '0;
      count <= '0;
      s_reg <= 1'b0;
      result <= '0;
    end else if (state == IDLE && start && !flush) begin
      a_reg <= a_in;
      b_reg <= b_in;
      s_reg <= set_flags;
      product <= accumulate ? acc_in : '0;
      count <= '0;
    end else if (state == RUN) begin
      product <= sum;
      a_reg <= a_reg << STEP;
      b_reg <= b_reg >> STEP;
      count <= count + CW'(1);
      if (last && !flush) result <= sum;
    end
  end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed checks of mul_unit (STEP=1 and STEP=4) against a cycle-level bench model
module tb_mul_unit;
  logic clk = 0, reset = 1, start = 0, accumulate = 0, set_flags = 0, flush = 0;
  logic [31:0] a_in = 0, b_in = 0, acc_in = 0;
  logic [1:0] busy_v, done_v;
  logic [31:0] res_v [2];
  logic [3:0] flg_v [2];
  logic [1:0] fw_v [2];
  int n_chk = 0, n_fail = 0;
  bit chk = 0;
  always #5 clk = ~clk;
  mul_unit #(.WIDTH(32), .STEP(1)) u_mul1 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate), .set_flags(set_flags),
    .flush(flush), .a_in(a_in), .b_in(b_in), .acc_in(acc_in), .busy(busy_v[0]), .done(done_v[0]),
    .result(res_v[0]), .alu_flags(flg_v[0]), .flag_write(fw_v[0]));
  mul_unit #(.WIDTH(32), .STEP(4)) u_mul4 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate), .set_flags(set_flags),
    .flush(flush), .a_in(a_in), .b_in(b_in), .acc_in(acc_in), .busy(busy_v[1]), .done(done_v[1]),
    .result(res_v[1]), .alu_flags(flg_v[1]), .flag_write(fw_v[1]));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic int nn(input int k);
    return k == 0 ? 32 : 8;
  endfunction
  // model: ph is the cycle index since acceptance (0 = idle, 1..n running, n+1 completing)
  int ph [2] = '{0, 0};
  logic [31:0] ex [2], rs [2];
  logic es [2];
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ph[k] = 0;
        rs[k] = 0;
      end else if (flush) ph[k] = 0;
      else if (ph[k] == 0) begin
        if (start) begin
          ph[k] = 1;
          ex[k] = (accumulate ? acc_in : 32'd0) + a_in * b_in;
          es[k] = set_flags;
        end
      end else if (ph[k] == nn(k) + 1) ph[k] = 0;
      else begin
        ph[k]++;
        if (ph[k] == nn(k) + 1) rs[k] = ex[k];
      end
    end
  always @(negedge clk)
    if (chk)
      for (int k = 0; k < 2; k++) begin
        logic d;
        d = ph[k] == nn(k) + 1 && !flush;
        check($sformatf("busy[%0d]", k), 32'(busy_v[k]), 32'(ph[k] >= 1 && ph[k] <= nn(k)));
        check($sformatf("done[%0d]", k), 32'(done_v[k]), 32'(d));
        check($sformatf("result[%0d]", k), res_v[k], rs[k]);
        check($sformatf("alu_flags[%0d]", k), 32'(flg_v[k]), d ? {28'd0, ex[k][31], ex[k] == 0, 2'b00} : 32'd0);
        check($sformatf("flag_write[%0d]", k), 32'(fw_v[k]), d ? {30'd0, es[k], 1'b0} : 32'd0);
      end
  int c0, c4, nd0;
  logic [31:0] cap_res, cap_after;
  logic [3:0] cap_flg;
  logic [1:0] cap_fw;
  logic cap_busy;
  // kind: 0 none, 1 flush, 2 extra start, 3 reset at cycle act; 4 flush together with the start
  task automatic run(input logic [31:0] a, b, acc, input logic accum, s, input int act, input int kind);
    a_in = a; b_in = b; acc_in = acc; accumulate = accum; set_flags = s; start = 1;
    if (kind == 4) flush = 1;
    @(posedge clk); #2;
    start = 0; flush = 0;
    a_in = $urandom; b_in = $urandom; acc_in = $urandom;
    accumulate = 1'($urandom_range(0, 1)); set_flags = 1'($urandom_range(0, 1));
    c0 = 0; c4 = 0; nd0 = 0; cap_busy = 1'bx; cap_after = 'x;
    for (int i = 1; i <= 40; i++) begin
      if (i == act) begin
        if (kind == 1) flush = 1;
        if (kind == 2) start = 1;
        if (kind == 3) reset = 1;
      end
      @(negedge clk);
      if (done_v[0]) begin
        c0 = i; nd0++; cap_res = res_v[0]; cap_flg = flg_v[0]; cap_fw = fw_v[0];
      end
      if (done_v[1]) c4 = i;
      if (i == act + 1) begin
        cap_busy = busy_v[0]; cap_after = res_v[0];
      end
      @(posedge clk); #2;
      flush = 0; start = 0; reset = 0;
    end
  endtask
  task automatic expect_ok(input string name, input logic [31:0] r, input logic [3:0] f, input logic [1:0] w);
    check({name, " lat1"}, 32'(c0), 32'd33);
    check({name, " lat4"}, 32'(c4), 32'd9);
    check({name, " ndone"}, 32'(nd0), 32'd1);
    check({name, " res"}, cap_res, r);
    check({name, " flags"}, 32'(cap_flg), 32'(f));
    check({name, " fw"}, 32'(cap_fw), 32'(w));
  endtask
  initial begin
    @(posedge clk); @(posedge clk); #2;
    chk = 1;
    @(negedge clk);
    check("rst busy", 32'(busy_v), 32'd0);
    check("rst done", 32'(done_v), 32'd0);
    check("rst result", res_v[0] | res_v[1], 32'd0);
    @(posedge clk); #2;
    reset = 0;
    run(32'd3, 32'd5, 32'd0, 0, 0, 0, 0);
    expect_ok("mul3x5", 32'h0000000F, 4'b0000, 2'b00);
    run(32'hFFFFFFFF, 32'd2, 32'd0, 0, 1, 0, 0);
    expect_ok("muls", 32'hFFFFFFFE, 4'b1000, 2'b10);
    run(32'h00010000, 32'h00010000, 32'd0, 1, 1, 0, 0);
    expect_ok("mlas0", 32'h0, 4'b0100, 2'b10);
    run(32'd7, 32'd6, 32'h100, 1, 0, 0, 0);
    expect_ok("mla", 32'h0000012A, 4'b0000, 2'b00);
    run(32'h1234, 32'h10, 32'd0, 0, 0, 10, 1);
    check("flush busy", 32'(cap_busy), 32'd0);
    check("flush ndone", 32'(nd0), 32'd0);
    check("flush res", cap_after, 32'h0000012A);
    run(32'd9, 32'd9, 32'd0, 0, 1, 0, 0);
    expect_ok("after flush", 32'h00000051, 4'b0000, 2'b10);
    run(32'h11, 32'h11, 32'd0, 0, 0, 5, 2);
    expect_ok("start in run", 32'h00000121, 4'b0000, 2'b00);
    run(32'd5, 32'd5, 32'd0, 0, 0, 0, 4);
    check("start+flush busy", 32'(cap_busy), 32'd0);
    check("start+flush ndone", 32'(nd0), 32'd0);
    check("start+flush lat4", 32'(c4), 32'd0);
    run(32'd3, 32'd3, 32'd0, 0, 0, 5, 3);
    check("reset busy", 32'(cap_busy), 32'd0);
    check("reset res", cap_after, 32'd0);
    check("reset ndone", 32'(nd0), 32'd0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 1, 1, 33, 1);
    check("flush done ndone", 32'(nd0), 32'd0);
    check("flush done lat4", 32'(c4), 32'd9);
    run(32'h80000000, 32'd1, 32'd0, 0, 1, 0, 0);
    expect_ok("neg", 32'h80000000, 4'b1000, 2'b10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
